arf_sched: RTL and testbench
============================

# arf_sched

Dynamic list scheduler that executes the 28-operation ARF dataflow graph (16 multiplies, 12 adds) on one shared pipelined multiplier and one shared pipelined adder, both outside this block. It captures one input frame, issues each ready operation to the matching unit, and writes results back into an internal result file. It returns the two ARF outputs (op 27, op 28) through a valid/ready handshake. It sits between the frame source and the time-shared arithmetic units used by the resource-constrained ARF variants.

## Interface
- `W`, 16: data width; all arithmetic is two's-complement and wraps modulo 2^W.
- `MUL_LAT`, 2: multiplier pipeline latency in cycles, ≥1.
- `ADD_LAT`, 1: adder pipeline latency in cycles, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1: frame handshake.
- `in_x` in 10*W: primary inputs x1..x8, x13, x14, with x1 in the LSBs.
- `cfg_we` in 1, `cfg_addr` in 4, `cfg_data` in W: coefficient write.
- `mul_go` out 1, `mul_a` out W, `mul_b` out W, `mul_p` in W: shared multiplier port.
- `add_go` out 1, `add_a` out W, `add_b` out W, `add_s` in W: shared adder port.
- `out_valid` out 1 / `out_ready` in 1, `out_27` out W, `out_28` out W: result handshake.

## Operation
- The DFG is fixed (cN = coefficient, mN/aN = op result):
  - m1..m8 = xk*ck.
  - a9 = m1+m2, a10 = m3+m4, a11 = m5+m6, a12 = m7+m8.
  - a13 = a9+x13, a14 = a11+x14.
  - m15 = a13*c15, m16 = a10*c16, m17 = a14*c17, m18 = a12*c18.
  - a19 = m15+m16, a20 = m17+m18.
  - m21 = a19*c21, m22 = a20*c22, m23 = a19*c23, m24 = a20*c24.
  - a25 = m21+m22, a26 = m23+m24, a27 = a25+a26, a28 = a26+a14.
- Coefficients: 16 registers. `cfg_addr` 0..7 maps to c1..c8, 8..11 to c15..c18, 12..15 to c21..c24. All reset to 0.
  - A write takes effect only in IDLE. A write in any other state is dropped.
- FSM states IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. When `in_valid`&`in_ready`, latch `in_x`, clear all 28 op-done/issued flags, go to RUN.
  - RUN: each cycle, issue at most one multiply and at most one add.
    - The chosen op is the lowest-numbered op of that kind that is not yet issued and whose operands are all done.
    - Issue drives `*_go`=1 with operand a = first listed source and b = second listed source.
    - When both op 27 and op 28 are done, go to DONE.
  - DONE: `out_valid`=1, `out_27`/`out_28` hold stable. When `out_valid`&`out_ready`, go to IDLE.
- Writeback: an op-id tag shift register per unit, of length MUL_LAT or ADD_LAT.
  - When a tag emerges, the controller samples `mul_p`/`add_s` into that op's result register and sets its done flag.
  - The controller does not use any valid signal from the units.
- When `*_go`=0, `*_a`/`*_b` are driven to 0.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE). `mul_go`, `add_go`, `out_valid`=0.
  - `mul_a`, `mul_b`, `add_a`, `add_b`, `out_27`, `out_28`=0.
  - Tag pipelines empty.
- An op issued in cycle t has its result sampled at the end of cycle t+LAT-1+1, i.e. the unit result is present in cycle t+LAT.
  - Dependents may issue in cycle t+LAT+1 at the earliest.
- The first issue (op 1) happens in the cycle after frame acceptance.
- The multiplier is the bottleneck. The lower bound on RUN length is 16 cycles plus the critical-path latency.
- `in_ready`=0 in RUN and DONE. A new frame is accepted no earlier than the cycle after the DONE handshake.
- `out_ready` may be held high in advance. DONE then lasts exactly 1 cycle.
- Simultaneous `cfg_we` and frame accept in IDLE: the write is applied first, so the frame uses the new coefficient.
- `rst` mid-RUN: return immediately to the reset values and discard tags. Unit outputs arriving later are ignored.

## Structure
- `arf_pkg` holds:
  - `NUM_OPS`=28 and the op kind enum {OP_MUL, OP_ADD}.
  - The source encoding enum {SRC_OP, SRC_X, SRC_C} with index.
  - The constant op table giving kind and two sources for each op.
  - The FSM state enum.
- Sub-module `arf_tag_pipe` (parameter DEPTH): valid+op-id delay line, cleared by `rst`. It is instantiated once per unit.

## Test plan
- Reset, then all x=1, coefficients c*=1, x13=x14=0, MUL_LAT=2/ADD_LAT=1 behavioural units → `out_27`=16, `out_28`=10; exactly 16 `mul_go` and 12 `add_go` pulses.
- Same frame with MUL_LAT=ADD_LAT=1 → identical outputs; no cycle with two `mul_go` ops in flight beyond the pipeline depth; no operand ever consumed before its writeback.
- x1=0x7FFF, c1=2, all other x and coefficients 0 except c15=c21=1 → wrap to 0xFFFE propagates; `out_27`=0xFFFE.
- `cfg_we` pulse during RUN with c1 changed → current and next frame results unaffected; a write made in IDLE is then used.
- `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_27`, `out_28` stable and `in_ready`=0; `in_valid` held high is accepted only after the handshake.
- Assert `rst` 3 cycles into RUN, then release and send a fresh frame → all outputs return to reset values; the fresh frame gives correct results unaffected by stale unit outputs.

Source files
------------

// File: rtl/arf_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arf_pkg
// Description : Shared types, the fixed 28-op ARF dataflow table and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package arf_pkg;

    localparam int NUM_OPS  = 28;
    localparam int NUM_X    = 10;
    localparam int NUM_COEF = 16;
    localparam int NUM_SRC  = NUM_OPS + NUM_X + NUM_COEF;
    localparam int OP_ID_W  = 5;

    typedef enum logic {OP_MUL = 1'b0, OP_ADD = 1'b1} op_kind_t;

    typedef enum logic [1:0] {SRC_OP = 2'd0, SRC_X = 2'd1, SRC_C = 2'd2} src_kind_t;

    typedef struct packed {
        src_kind_t   kind;
        logic [4:0]  idx;
    } src_t;

    typedef struct packed {
        op_kind_t kind;
        src_t     a;
        src_t     b;
    } op_ent_t;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    // n is the 1-based op number as written in the dataflow graph
    function automatic src_t s_op(input int n);
        return '{SRC_OP, 5'(n - 1)};
    endfunction

    function automatic src_t s_x(input int k);
        return '{SRC_X, 5'(k)};
    endfunction

    function automatic src_t s_c(input int k);
        return '{SRC_C, 5'(k)};
    endfunction

    function automatic op_ent_t op_table(input int n);
        case (n)
            1, 2, 3, 4,
            5, 6, 7, 8: return '{OP_MUL, s_x(n - 1),  s_c(n - 1)};
            9:          return '{OP_ADD, s_op(1),     s_op(2)};
            10:         return '{OP_ADD, s_op(3),     s_op(4)};
            11:         return '{OP_ADD, s_op(5),     s_op(6)};
            12:         return '{OP_ADD, s_op(7),     s_op(8)};
            13:         return '{OP_ADD, s_op(9),     s_x(8)};
            14:         return '{OP_ADD, s_op(11),    s_x(9)};
            15:         return '{OP_MUL, s_op(13),    s_c(8)};
            16:         return '{OP_MUL, s_op(10),    s_c(9)};
            17:         return '{OP_MUL, s_op(14),    s_c(10)};
            18:         return '{OP_MUL, s_op(12),    s_c(11)};
            19:         return '{OP_ADD, s_op(15),    s_op(16)};
            20:         return '{OP_ADD, s_op(17),    s_op(18)};
            21:         return '{OP_MUL, s_op(19),    s_c(12)};
            22:         return '{OP_MUL, s_op(20),    s_c(13)};
            23:         return '{OP_MUL, s_op(19),    s_c(14)};
            24:         return '{OP_MUL, s_op(20),    s_c(15)};
            25:         return '{OP_ADD, s_op(21),    s_op(22)};
            26:         return '{OP_ADD, s_op(23),    s_op(24)};
            27:         return '{OP_ADD, s_op(25),    s_op(26)};
            default:    return '{OP_ADD, s_op(26),    s_op(14)};
        endcase
    endfunction

    // Flat index into the combined operand space: op results, then x, then coefficients
    function automatic int src_flat(input src_t s);
        case (s.kind)
            SRC_OP:  return int'(s.idx);
            SRC_X:   return NUM_OPS + int'(s.idx);
            default: return NUM_OPS + NUM_X + int'(s.idx);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/arf_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : arf_sched_if
// Description : Frame, coefficient, shared-unit and result signals of arf_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface arf_sched_if #(
    parameter int W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [10*W-1:0]   in_x;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [W-1:0]      cfg_data;
    logic              mul_go;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_p;
    logic              add_go;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_s;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_27;
    logic [W-1:0]      out_28;

    // Scheduler side
    modport master (
        input  in_valid, in_x, cfg_we, cfg_addr, cfg_data, mul_p, add_s, out_ready,
        output in_ready, mul_go, mul_a, mul_b, add_go, add_a, add_b,
        output out_valid, out_27, out_28
    );

    // Frame source, arithmetic units and result sink side
    modport slave (
        output in_valid, in_x, cfg_we, cfg_addr, cfg_data, mul_p, add_s, out_ready,
        input  in_ready, mul_go, mul_a, mul_b, add_go, add_a, add_b,
        input  out_valid, out_27, out_28
    );
endinterface
`default_nettype wire

// File: rtl/arf_sched_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arf_tag_pipe
// Description : Valid + op-id delay line tracking results in flight in a unit.
// Revision    : 1.0 - initial release
// ============================================================================
module arf_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int ID_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [ID_W-1:0] i_id,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);
    logic [DEPTH-1:0] r_vld;
    logic [ID_W-1:0]  r_id [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) r_id[i] <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_id[0]  <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/arf_sched.sv
`default_nettype none
// ============================================================================
// Module      : arf_sched
// Description : List scheduler running the ARF DFG on one shared mul and add.
// Revision    : 1.0 - initial release
// ============================================================================
module arf_sched
    import arf_pkg::*;
#(
    parameter int W       = 16,
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    arf_sched_if.master bus
);
    state_t               r_state, w_state_nxt;
    logic                 w_accept;
    logic [W-1:0]         r_x    [NUM_X];
    logic [W-1:0]         r_coef [NUM_COEF];
    logic [W-1:0]         r_res  [NUM_OPS];
    logic [NUM_OPS-1:0]   r_done, r_issued;
    logic [W-1:0]         w_src  [NUM_SRC];
    logic [NUM_SRC-1:0]   w_avail;
    logic [W-1:0]         w_opa  [NUM_OPS];
    logic [W-1:0]         w_opb  [NUM_OPS];
    logic [NUM_OPS-1:0]   w_rdy, w_is_mul;
    logic                 w_mul_go, w_add_go, w_mul_wb, w_add_wb;
    logic [OP_ID_W-1:0]   w_mul_id, w_add_id, w_mul_wb_id, w_add_wb_id;

    always_comb begin
        for (int i = 0; i < NUM_OPS; i++)  w_src[i] = r_res[i];
        for (int i = 0; i < NUM_X; i++)    w_src[NUM_OPS + i] = r_x[i];
        for (int i = 0; i < NUM_COEF; i++) w_src[NUM_OPS + NUM_X + i] = r_coef[i];
    end

    // Primary inputs and coefficients are always available; op results once written back
    assign w_avail = {{(NUM_X + NUM_COEF){1'b1}}, r_done};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        localparam op_ent_t E  = op_table(g + 1);
        localparam int      FA = src_flat(E.a);
        localparam int      FB = src_flat(E.b);
        assign w_is_mul[g] = (E.kind == OP_MUL);
        assign w_rdy[g]    = !r_issued[g] && w_avail[FA] && w_avail[FB];
        assign w_opa[g]    = w_src[FA];
        assign w_opb[g]    = w_src[FB];
    end

    // Descending scan so the lowest-numbered ready op of each kind wins
    always_comb begin
        w_mul_go = 1'b0;
        w_mul_id = '0;
        w_add_go = 1'b0;
        w_add_id = '0;
        if (r_state == ST_RUN) begin
            for (int i = NUM_OPS - 1; i >= 0; i--) begin
                if (w_rdy[i] && w_is_mul[i]) begin
                    w_mul_go = 1'b1;
                    w_mul_id = OP_ID_W'(i);
                end
                if (w_rdy[i] && !w_is_mul[i]) begin
                    w_add_go = 1'b1;
                    w_add_id = OP_ID_W'(i);
                end
            end
        end
    end

    arf_tag_pipe #(.DEPTH(MUL_LAT), .ID_W(OP_ID_W)) u_mul_tag (
        .clk(clk), .rst(rst), .i_valid(w_mul_go), .i_id(w_mul_id),
        .o_valid(w_mul_wb), .o_id(w_mul_wb_id)
    );

    arf_tag_pipe #(.DEPTH(ADD_LAT), .ID_W(OP_ID_W)) u_add_tag (
        .clk(clk), .rst(rst), .i_valid(w_add_go), .i_id(w_add_id),
        .o_valid(w_add_wb), .o_id(w_add_wb_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (r_done[26] && r_done[27]) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_X; i++)    r_x[i]    <= '0;
            for (int i = 0; i < NUM_COEF; i++) r_coef[i] <= '0;
            for (int i = 0; i < NUM_OPS; i++)  r_res[i]  <= '0;
            r_done   <= '0;
            r_issued <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.cfg_we) r_coef[bus.cfg_addr] <= bus.cfg_data;
            if (w_accept) begin
                for (int i = 0; i < NUM_X; i++) r_x[i] <= bus.in_x[i*W +: W];
                r_done   <= '0;
                r_issued <= '0;
            end else begin
                if (w_mul_go) r_issued[w_mul_id] <= 1'b1;
                if (w_add_go) r_issued[w_add_id] <= 1'b1;
                if (w_mul_wb) begin
                    r_res[w_mul_wb_id]  <= bus.mul_p;
                    r_done[w_mul_wb_id] <= 1'b1;
                end
                if (w_add_wb) begin
                    r_res[w_add_wb_id]  <= bus.add_s;
                    r_done[w_add_wb_id] <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_27    = r_res[26];
    assign bus.out_28    = r_res[27];
    assign bus.mul_go    = w_mul_go;
    assign bus.mul_a     = w_mul_go ? w_opa[w_mul_id] : '0;
    assign bus.mul_b     = w_mul_go ? w_opb[w_mul_id] : '0;
    assign bus.add_go    = w_add_go;
    assign bus.add_a     = w_add_go ? w_opa[w_add_id] : '0;
    assign bus.add_b     = w_add_go ? w_opb[w_add_id] : '0;
endmodule
`default_nettype wire

// File: tb/tb_arf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_arf_sched
// Description : Directed bench for arf_sched with behavioural pipelined units.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arf_sched;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arf_sched_if #(.W(W)) bus_a ();
    arf_sched_if #(.W(W)) bus_b ();

    arf_sched #(.W(W), .MUL_LAT(2), .ADD_LAT(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    arf_sched #(.W(W), .MUL_LAT(1), .ADD_LAT(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_x      = bus_a.in_x;
    assign bus_b.cfg_we    = bus_a.cfg_we;
    assign bus_b.cfg_addr  = bus_a.cfg_addr;
    assign bus_b.cfg_data  = bus_a.cfg_data;
    assign bus_b.out_ready = bus_a.out_ready;

    // Behavioural units; they never reset, so stale products can linger
    logic [W-1:0] r_ma1, r_ma2, r_aa1, r_mb1, r_ab1;
    always @(posedge clk) begin
        r_ma1 <= bus_a.mul_a * bus_a.mul_b;
        r_ma2 <= r_ma1;
        r_aa1 <= bus_a.add_a + bus_a.add_b;
        r_mb1 <= bus_b.mul_a * bus_b.mul_b;
        r_ab1 <= bus_b.add_a + bus_b.add_b;
    end
    assign bus_a.mul_p = r_ma2;
    assign bus_a.add_s = r_aa1;
    assign bus_b.mul_p = r_mb1;
    assign bus_b.add_s = r_ab1;

    int n_total = 0;
    int n_bad   = 0;
    int n_mul, n_add, n_vld;
    logic [W-1:0]    b27, b28, v27;
    logic [10*W-1:0] xv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus_a.mul_go)    n_mul++;
        if (bus_a.add_go)    n_add++;
        if (bus_a.out_valid) n_vld++;
        if (bus_b.out_valid) begin
            b27 = bus_b.out_27;
            b28 = bus_b.out_28;
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [W-1:0] data);
        bus_a.cfg_addr = addr;
        bus_a.cfg_data = data;
        bus_a.cfg_we   = 1'b1;
        tick();
        bus_a.cfg_we   = 1'b0;
    endtask

    task automatic send_frame(input logic [10*W-1:0] x);
        bus_a.in_x     = x;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (bus_a.out_valid) break;
            tick();
        end
        check_val({tag, "_done"}, 32'(bus_a.out_valid), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [10*W-1:0] x,
                             input logic [W-1:0] e27, input logic [W-1:0] e28);
        send_frame(x);
        wait_done(tag);
        check_val({tag, "_o27"}, 32'(bus_a.out_27), 32'(e27));
        check_val({tag, "_o28"}, 32'(bus_a.out_28), 32'(e28));
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_x     = '0;
        bus_a.cfg_we   = 1'b0;
        bus_a.cfg_addr = '0;
        bus_a.cfg_data = '0;
        bus_a.out_ready = 1'b1;
        n_mul = 0; n_add = 0; n_vld = 0;
        b27 = '0; b28 = '0;
        repeat (2) tick();
        check_val("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
        check_val("rst_mul_go",    32'(bus_a.mul_go),    32'd0);
        check_val("rst_add_go",    32'(bus_a.add_go),    32'd0);
        check_val("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("rst_mul_a",     32'(bus_a.mul_a),     32'd0);
        check_val("rst_out_27",    32'(bus_a.out_27),    32'd0);
        rst = 1'b0;
        tick();

        // All-ones frame on both latency configurations
        for (int a = 0; a < 16; a++) cfg_write(4'(a), 16'd1);
        xv = '0;
        for (int k = 0; k < 8; k++) xv[k*W +: W] = 16'd1;
        n_mul = 0; n_add = 0; n_vld = 0;
        b27 = 16'hDEAD; b28 = 16'hDEAD;
        send_frame(xv);
        check_val("t1_first_go", 32'(bus_a.mul_go),   32'd1);
        check_val("t1_first_a",  32'(bus_a.mul_a),    32'd1);
        check_val("t1_in_ready", 32'(bus_a.in_ready), 32'd0);
        wait_done("t1");
        check_val("t1_o27", 32'(bus_a.out_27), 32'd16);
        check_val("t1_o28", 32'(bus_a.out_28), 32'd10);
        repeat (4) tick();
        check_val("t1_mul_cnt", 32'(n_mul), 32'd16);
        check_val("t1_add_cnt", 32'(n_add), 32'd12);
        check_val("t1_vld_cyc", 32'(n_vld), 32'd1);
        check_val("t1_b_o27",   32'(b27),   32'd16);
        check_val("t1_b_o28",   32'(b28),   32'd10);

        // Wrap: 0x7FFF*2 = 0xFFFE carried through the c15/c21 chain
        for (int a = 0; a < 16; a++)
            cfg_write(4'(a), (a == 0) ? 16'd2 : ((a == 8 || a == 12) ? 16'd1 : 16'd0));
        xv = '0;
        xv[W-1:0] = 16'h7FFF;
        run_frame("t3", xv, 16'hFFFE, 16'h0000);

        // Coefficient write during RUN is dropped: x1=3, c1 stays 2 -> 6
        xv = '0;
        xv[W-1:0] = 16'd3;
        send_frame(xv);
        tick();
        cfg_write(4'd0, 16'd7);
        wait_done("t4a");
        check_val("t4a_o27", 32'(bus_a.out_27), 32'd6);
        tick();
        run_frame("t4b", xv, 16'd6, 16'd0);
        cfg_write(4'd0, 16'd7);
        run_frame("t4c", xv, 16'd21, 16'd0);

        // Write coincident with accept: frame sees c1=4 -> 12
        bus_a.cfg_addr = 4'd0;
        bus_a.cfg_data = 16'd4;
        bus_a.cfg_we   = 1'b1;
        bus_a.in_x     = xv;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.cfg_we   = 1'b0;
        bus_a.in_valid = 1'b0;
        wait_done("t4d");
        check_val("t4d_o27", 32'(bus_a.out_27), 32'd12);
        tick();

        // Back-pressure in DONE with the next frame already offered
        bus_a.out_ready = 1'b0;
        send_frame(xv);
        wait_done("t5");
        v27 = bus_a.out_27;
        check_val("t5_o27", 32'(v27), 32'd12);
        xv = '0;
        xv[W-1:0] = 16'd1;
        bus_a.in_x     = xv;
        bus_a.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("t5_hold_valid", 32'(bus_a.out_valid), 32'd1);
            check_val("t5_hold_o27",   32'(bus_a.out_27),    32'd12);
            check_val("t5_hold_ready", 32'(bus_a.in_ready),  32'd0);
        end
        bus_a.out_ready = 1'b1;
        tick();
        check_val("t5_idle_ready", 32'(bus_a.in_ready),  32'd1);
        check_val("t5_idle_valid", 32'(bus_a.out_valid), 32'd0);
        tick();
        bus_a.in_valid = 1'b0;
        check_val("t5_accepted", 32'(bus_a.in_ready), 32'd0);
        wait_done("t5b");
        check_val("t5b_o27", 32'(bus_a.out_27), 32'd4);
        tick();

        // Reset three cycles into RUN
        send_frame(xv);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_val("t6_in_ready",  32'(bus_a.in_ready),  32'd1);
        check_val("t6_mul_go",    32'(bus_a.mul_go),    32'd0);
        check_val("t6_add_go",    32'(bus_a.add_go),    32'd0);
        check_val("t6_mul_a",     32'(bus_a.mul_a),     32'd0);
        check_val("t6_out_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("t6_out_27",    32'(bus_a.out_27),    32'd0);
        check_val("t6_out_28",    32'(bus_a.out_28),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        // Coefficients are now zero: out_27=0, out_28=x14
        xv = '0;
        xv[8*W +: W] = 16'd3;
        xv[9*W +: W] = 16'd5;
        run_frame("t6a", xv, 16'd0, 16'd5);
        for (int a = 0; a < 16; a++) cfg_write(4'(a), 16'd1);
        xv = '0;
        for (int k = 0; k < 8; k++) xv[k*W +: W] = 16'd1;
        run_frame("t6b", xv, 16'd16, 16'd10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
